// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: op codes, FSM states and
// op classification used by the RTL and the testbench.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic logic is_signed(div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem(div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Request/response bundle of the iterative divider; the execute stage drives
// the master side, the divider implements the slave side.
interface iterative_divider_if #(
    parameter int WIDTH = 32
);
    import div_pkg::*;

    logic             flush;
    logic             start;
    div_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] result;

    modport master (
        output flush, start, op, a, b,
        input  ready, busy, done, quotient, remainder, result
    );

    modport slave (
        input  flush, start, op, a, b,
        output ready, busy, done, quotient, remainder, result
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra top bit of diff acts as the borrow: set means the divisor did not fit.
    assign shifted  = {rem, dvd_msb};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: magnitudes are divided one
// bit per cycle, signs are restored in FIX, and results are registered on entering DONE.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    iterative_divider_if.slave bus
);

    localparam int                CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;
    div_op_t          op_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_out_q;
    logic [WIDTH-1:0] result_q;

    logic             accept;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_by_zero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] special_q;
    logic [WIDTH-1:0] special_r;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    assign accept      = bus.start && ready_q && !bus.flush;
    assign signed_op   = is_signed(bus.op);
    assign a_neg       = signed_op && bus.a[WIDTH-1];
    assign b_neg       = signed_op && bus.b[WIDTH-1];
    assign a_mag       = a_neg ? -bus.a : bus.a;
    assign b_mag       = b_neg ? -bus.b : bus.b;

    // Both special cases finish without iterating; divide-by-zero takes priority.
    assign div_by_zero = (bus.b == '0);
    assign overflow    = signed_op && (bus.a == MOST_NEG) && (bus.b == '1);
    assign special     = div_by_zero || overflow;
    assign special_q   = div_by_zero ? '1 : bus.a;
    assign special_r   = div_by_zero ? bus.a : '0;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (divisor),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    assign fix_q = neg_q ? -dvd : dvd;
    assign fix_r = neg_r ? -rem : rem;

    // NOTE: every register here, datapath included, sits behind the async reset so a
    // reset mid-division leaves no stale operands or results visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            divisor   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            op_q      <= DIV;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below reads
            // the pre-edge register values regardless of statement order.
            done_q <= 1'b0;
            if (bus.flush) begin
                state   <= IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (accept) begin
                            op_q <= bus.op;
                            cnt  <= CNT_LAST;
                            rem  <= '0;
                            if (special) begin
                                state     <= DONE;
                                done_q    <= 1'b1;
                                ready_q   <= 1'b1;
                                busy_q    <= 1'b0;
                                quot_q    <= special_q;
                                rem_out_q <= special_r;
                                result_q  <= is_rem(bus.op) ? special_r : special_q;
                            end else begin
                                state   <= CALC;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                                dvd     <= a_mag;
                                divisor <= b_mag;
                                neg_q   <= a_neg ^ b_neg;
                                neg_r   <= a_neg;
                            end
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    CALC: begin
                        // Quotient bits enter dvd from the bottom as dividend bits leave the top.
                        rem <= step_rem;
                        dvd <= {dvd[WIDTH-2:0], step_q};
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    FIX: begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        quot_q    <= fix_q;
                        rem_out_q <= fix_r;
                        result_q  <= is_rem(op_q) ? fix_r : fix_q;
                    end
                    default: begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_out_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed vector table, handshake
// corner sequences, and random ops against an arithmetic reference model.
module tb_iterative_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic plus the two RV32M special-case rules.
    function automatic void model(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb;
        logic sgn;
        sgn = (op == DIV) || (op == REM);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; lat = 1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb); r = 32'(sa % sb); lat = W + 2;
        end else begin
            q = a / b; r = a % b; lat = W + 2;
        end
    endfunction

    function automatic logic [31:0] pick(input div_op_t op, input logic [31:0] q, input logic [31:0] r);
        return ((op == REM) || (op == REMU)) ? r : q;
    endfunction

    task automatic run_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        q = bus.quotient; r = bus.remainder; res = bus.result;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t        vecs[12];
    logic [31:0] q, r, res, eq, er;
    int          lat, elat, seen;
    div_op_t     rop;
    logic [31:0] ra, rb;

    initial begin
        n_cmp = 0; n_err = 0;
        bus.flush = 1'b0; bus.start = 1'b0; bus.op = DIVU; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        #12;
        check("reset_ready",     32'(bus.ready), 32'd1);
        check("reset_busy",      32'(bus.busy), 32'd0);
        check("reset_done",      32'(bus.done), 32'd0);
        check("reset_quotient",  bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_result",    bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{DIVU, 32'd100,        32'd7,        32'd14,        32'd2,        34};
        vecs[1]  = '{DIV,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{REM,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{DIVU, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 32'h0000_1234, 1};
        vecs[4]  = '{DIV,  32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1};
        vecs[5]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1};
        vecs[6]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1};
        vecs[7]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        34};
        vecs[8]  = '{DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       34};
        vecs[9]  = '{REMU, 32'd5,          32'd10,       32'd0,         32'd5,        34};
        vecs[10] = '{DIV,  32'h8000_0000,  32'd2,        32'hC000_0000, 32'd0,        34};
        vecs[11] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 34};

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, q, r, res, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_result", i), res, pick(vecs[i].op, vecs[i].q, vecs[i].r));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("vec%0d_hold", i), bus.quotient, vecs[i].q);
        end

        // Flush mid-CALC: no done, prior result kept, then a clean re-issue.
        run_op(DIVU, 32'd77, 32'd4, q, r, res, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd50; bus.b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0; bus.start = 1'b0;
        check("flush_ready",     32'(bus.ready), 32'd1);
        check("flush_busy",      32'(bus.busy), 32'd0);
        check("flush_done",      32'(bus.done), 32'd0);
        check("flush_hold_q",    bus.quotient, 32'd19);
        check("flush_hold_r",    bus.remainder, 32'd1);
        check("flush_hold_res",  bus.result, 32'd19);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd50; bus.b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0; bus.start = 1'b0;
        check("flush_beats_start_busy", 32'(bus.busy), 32'd0);
        check("flush_beats_start_done", 32'(bus.done), 32'd0);
        run_op(DIVU, 32'd50, 32'd5, q, r, res, lat);
        check("reissue_latency",  32'(lat), 32'd34);
        check("reissue_quotient", q, 32'd10);
        check("reissue_remainder", r, 32'd0);

        // Back-to-back with start held high; operand changes while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd9; bus.b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.a = 32'd20; bus.b = 32'd3;
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'd34);
        check("b2b_first_q", bus.quotient, 32'd4);
        check("b2b_first_r", bus.remainder, 32'd1);
        check("b2b_done_ready", 32'(bus.ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_second_accepted", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("b2b_second_latency", 32'(lat), 32'd34);
        check("b2b_second_q", bus.quotient, 32'd6);
        check("b2b_second_r", bus.remainder, 32'd2);

        // Asynchronous reset mid-CALC, observed between clock edges.
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready",     32'(bus.ready), 32'd1);
        check("arst_busy",      32'(bus.busy), 32'd0);
        check("arst_done",      32'(bus.done), 32'd0);
        check("arst_quotient",  bus.quotient, 32'd0);
        check("arst_remainder", bus.remainder, 32'd0);
        check("arst_result",    bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random ops against the reference model, biased towards the corner operands.
        for (int i = 0; i < 150; i++) begin
            rop = div_op_t'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2:    rb = 32'hFFFF_FFFF;
                3:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, eq, er, elat);
            run_op(rop, ra, rb, q, r, res, lat);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
            check($sformatf("rnd%0d_quotient", i), q, eq);
            check($sformatf("rnd%0d_remainder", i), r, er);
            check($sformatf("rnd%0d_result", i), res, pick(rop, eq, er));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
